// File: rtl/ram_wb_arbiter.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter with round-robin locked grant,
// outstanding-request tracking, response routing to the owner and a no-response watchdog.
module ram_wb_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    output logic        m0_stall_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic        m1_stall_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    input  logic        s_stall_i,
    output logic        busy_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int WW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic        granted, owner_is1, owner_cyc, owner_stb, other_cyc;
    logic        cap_ok, pending, resp_valid, accept, abort;
    logic        owner_stall, owner_ack, owner_err, owner_rty;
    logic [31:0] owner_dat;

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            outstanding_q <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            outstanding_q <= outstanding_d;
            wdog_q        <= wdog_d;
        end
    end

    // Datapath: the owner's request goes to the slave, slave responses go straight back.
    always_comb begin
        granted    = (state_q != IDLE);
        owner_is1  = (state_q == GRANT1);
        owner_cyc  = owner_is1 ? m1_cyc_i : m0_cyc_i;
        owner_stb  = owner_is1 ? m1_stb_i : m0_stb_i;
        other_cyc  = owner_is1 ? m0_cyc_i : m1_cyc_i;
        cap_ok     = (outstanding_q < OUT_MAX);
        pending    = (outstanding_q != '0);
        abort      = granted & owner_cyc & pending & (wdog_q == WDOG_LIMIT);
        resp_valid = granted & owner_cyc & pending & (s_ack_i | s_err_i | s_rty_i);

        s_cyc_o = granted & owner_cyc & ~abort;
        s_stb_o = granted & owner_cyc & owner_stb & cap_ok & ~abort;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (granted) begin
            s_we_o  = owner_is1 ? m1_we_i  : m0_we_i;
            s_adr_o = owner_is1 ? m1_adr_i : m0_adr_i;
            s_dat_o = owner_is1 ? m1_dat_i : m0_dat_i;
            s_sel_o = owner_is1 ? m1_sel_i : m0_sel_i;
        end
        accept = s_stb_o & ~s_stall_i;

        // Stall during an abort too, so the owner never believes a dropped strobe was taken.
        owner_stall = s_stall_i | ~cap_ok | abort;
        owner_ack   = s_ack_i & resp_valid & ~abort;
        owner_err   = (s_err_i & resp_valid) | abort;
        owner_rty   = s_rty_i & resp_valid & ~abort;
        owner_dat   = owner_cyc ? s_dat_i : '0;

        m0_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m0_dat_o   = '0;
        m1_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        m1_dat_o   = '0;
        if (state_q == GRANT0) begin
            m0_stall_o = owner_stall;
            m0_ack_o   = owner_ack;
            m0_err_o   = owner_err;
            m0_rty_o   = owner_rty;
            m0_dat_o   = owner_dat;
        end else if (state_q == GRANT1) begin
            m1_stall_o = owner_stall;
            m1_ack_o   = owner_ack;
            m1_err_o   = owner_err;
            m1_rty_o   = owner_rty;
            m1_dat_o   = owner_dat;
        end
        busy_o = granted;
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        outstanding_d = outstanding_q;
        wdog_d        = wdog_q;
        case (state_q)
            IDLE: begin
                outstanding_d = '0;
                wdog_d        = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (m0_cyc_i) begin
                    state_d = GRANT0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                end
            end
            default: begin
                if (!owner_cyc) begin
                    // Release hands over directly when the other master is already waiting.
                    outstanding_d = '0;
                    wdog_d        = '0;
                    last_d        = owner_is1;
                    if (other_cyc) begin
                        state_d = owner_is1 ? GRANT0 : GRANT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (abort) begin
                    outstanding_d = '0;
                    wdog_d        = '0;
                end else begin
                    case ({accept, resp_valid})
                        2'b10:   outstanding_d = outstanding_q + 1'b1;
                        2'b01:   outstanding_d = outstanding_q - 1'b1;
                        default: outstanding_d = outstanding_q;
                    endcase
                    if (accept || resp_valid || !pending) begin
                        wdog_d = '0;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule
